mips_trace_buffer: RTL and testbench
====================================

MIPS_TRACE_BUFFER -- requirements
Module: mips_trace_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, the width of the traced processor test value.
REQ-002 SHALL have parameter TS_W, default 16, the timestamp width.
REQ-003 SHALL have parameter DEPTH, default 16, the number of trace entries; it is a power of two and at least 2.
REQ-004 SHALL have parameter MODE, default 0, where 0 captures on change and 1 captures every cycle.
REQ-005 SHALL have parameter FULL_POLICY, default 0, where 0 stops capture on full and 1 overwrites the oldest entry.
REQ-006 SHALL have parameter HALT_CYCLES, default 8, the number of stable cycles that flags a processor halt; it is at least 2.
REQ-007 SHALL have port CLK, input, 1 bit: the single clock, rising-edge.
REQ-008 SHALL have port RST, input, 1 bit: reset, synchronous, active-low.
REQ-009 SHALL have port Test_Value, input, DATA_W bits: the processor test value being traced.
REQ-010 SHALL have port Capture_En, input, 1 bit: arms capture while high.
REQ-011 SHALL have port Rd_En, input, 1 bit: pops the oldest entry.
REQ-012 SHALL have port Rd_Data, output, DATA_W bits: the popped value.
REQ-013 SHALL have port Rd_Ts, output, TS_W bits: the timestamp of the popped entry.
REQ-014 SHALL have port Rd_Valid, output, 1 bit: one-cycle strobe qualifying Rd_Data and Rd_Ts.
REQ-015 SHALL have output ports Empty and Full, 1 bit each: FIFO status.
REQ-016 SHALL have port Count, output, clog2(DEPTH)+1 bits: number of stored entries.
REQ-017 SHALL have port Overflow, output, 1 bit: sticky flag set when a capture is lost or an entry is overwritten.
REQ-018 SHALL have port Halt_Detected, output, 1 bit: sticky flag set on processor halt.
REQ-019 SHALL have port State, output, 2 bits: the current FSM state.

Function
REQ-020 SHALL implement FSM states IDLE=0, RUN=1 and STOPPED=2; encoding 3 SHALL be unreachable and SHALL recover to IDLE.
REQ-021 SHALL transition IDLE->RUN when Capture_En=1, RUN->IDLE when Capture_En=0, RUN->STOPPED on halt or on full with FULL_POLICY=0, and STOPPED->IDLE when Capture_En=0.
REQ-022 SHALL clear the timestamp counter on IDLE->RUN and increment it by 1 on every cycle in RUN, wrapping modulo 2^TS_W.
REQ-023 SHALL capture in RUN when MODE=1, when Test_Value differs from the last sampled value, or on the first RUN cycle.
REQ-024 SHALL write each capture to the FIFO as {Test_Value, timestamp}; the entry SHALL be visible in Count on the next cycle.
REQ-025 SHALL, on a capture while Full with FULL_POLICY=0, drop the capture, set Overflow and enter STOPPED.
REQ-026 SHALL, on a capture while Full with FULL_POLICY=1, drop the oldest entry, write the new one, leave Count at DEPTH and set Overflow.
REQ-027 SHALL, on Rd_En with Empty=0, produce Rd_Valid=1 with the oldest entry exactly one cycle later.
REQ-028 SHALL ignore Rd_En while Empty=1, with Rd_Valid=0 and Rd_Data/Rd_Ts held.
REQ-029 SHALL, on a simultaneous read and write while Full, perform both with Count unchanged and Overflow not set.
REQ-030 SHALL, on a simultaneous read and write while Empty, ignore the read and store the write.
REQ-031 SHALL reads remain legal in every state, including IDLE and STOPPED.
REQ-032 SHALL count, in RUN, consecutive cycles with Test_Value unchanged; on reaching HALT_CYCLES it SHALL set Halt_Detected and enter STOPPED.
REQ-033 SHALL clear the stable counter on any change of Test_Value.
REQ-034 SHALL clear Overflow and Halt_Detected on IDLE->RUN; the FIFO contents SHALL be kept.
REQ-035 SHALL wrap the FIFO pointers modulo DEPTH, with Full and Empty derived from Count.

Reset
REQ-036 SHALL, on RST=0 at a rising CLK edge, set State=IDLE, Count=0, Empty=1, Full=0, Overflow=0, Halt_Detected=0, Rd_Valid=0, Rd_Data=0, Rd_Ts=0, timestamp=0 and the stable counter to 0.
REQ-037 SHALL, on reset mid-capture or mid-read, discard all entries and drop any pending Rd_Valid.

Structure
REQ-038 SHALL place the state encodings, MODE and FULL_POLICY constants, and the entry-width function in package mips_trace_pkg.
REQ-039 SHALL implement storage in sub-module trace_fifo, a parametrised synchronous FIFO with overwrite support.

Verification
REQ-040 SHALL verify MODE=0, DEPTH=4: Test_Value 5,5,7,7,9 in RUN from timestamp 0, then three reads -> (5,0),(7,2),(9,4), then Empty=1.
REQ-041 SHALL verify FULL_POLICY=0, DEPTH=4, MODE=1: six RUN cycles -> Count=4, Overflow=1 on the 5th capture, State=STOPPED, and reads return timestamps 0..3.
REQ-042 SHALL verify FULL_POLICY=1, DEPTH=4, MODE=1: six captures -> Count=4, Overflow=1, and reads return timestamps 2..5.
REQ-043 SHALL verify HALT_CYCLES=8 with Test_Value held at 3 -> Halt_Detected=1 and State=STOPPED on the 8th stable cycle, and toggling Capture_En clears the flag.
REQ-044 SHALL verify read while Empty -> Rd_Valid stays 0, and read+write while Full -> Count stays 4.
REQ-045 SHALL verify RST=0 mid-run with Count=3 -> next cycle Count=0, Empty=1, State=IDLE, and no Rd_Valid.

Source files
------------

// File: rtl/mips_trace_pkg.sv
// mips_trace_pkg: shared states, capture/full policy codes and entry sizing for the trace buffer
package mips_trace_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_STOPPED = 2'd2
  } state_t;
  localparam int MODE_CHANGE    = 0;
  localparam int MODE_EVERY     = 1;
  localparam int FULL_STOP      = 0;
  localparam int FULL_OVERWRITE = 1;
  function automatic int entry_w(input int dw, input int tw);
    return dw + tw;
  endfunction
endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: synchronous FIFO with optional overwrite-oldest on full and a registered read port
module trace_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_wr,
  input  logic                   i_ovw,
  input  logic                   i_rd,
  input  logic [W-1:0]           i_wr_data,
  output logic [W-1:0]           o_rd_data,
  output logic                   o_rd_valid,
  output logic                   o_empty,
  output logic                   o_full,
  output logic                   o_lost,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic [W-1:0] r_rd_data;
  logic r_rd_valid;
  logic w_rd, w_push, w_pop;
  assign o_empty    = r_cnt == '0;
  assign o_full     = r_cnt == (AW+1)'(DEPTH);
  assign w_rd       = i_rd && !o_empty;
  // a write into a full FIFO is only lossless when a read frees a slot the same cycle
  assign o_lost     = i_wr && o_full && !w_rd;
  assign w_push     = i_wr && (!o_lost || i_ovw);
  assign w_pop      = w_rd || (o_lost && i_ovw);
  assign o_count    = r_cnt;
  assign o_rd_data  = r_rd_data;
  assign o_rd_valid = r_rd_valid;
  always_ff @(posedge i_clk)
    if (w_push) r_mem[r_wp] <= i_wr_data;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_cnt      <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_wp       <= r_wp + AW'(w_push);
      r_rp       <= r_rp + AW'(w_pop);
      r_cnt      <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      r_rd_valid <= w_rd;
      if (w_rd) r_rd_data <= r_mem[r_rp];
    end
  end
endmodule

// File: rtl/mips_trace_buffer.sv
// mips_trace_buffer: timestamped trace capture of a processor test value with halt detection
module mips_trace_buffer
  import mips_trace_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int TS_W        = 16,
  parameter int DEPTH       = 16,
  parameter int MODE        = MODE_CHANGE,
  parameter int FULL_POLICY = FULL_STOP,
  parameter int HALT_CYCLES = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [DATA_W-1:0]      Test_Value,
  input  logic                   Capture_En,
  input  logic                   Rd_En,
  output logic [DATA_W-1:0]      Rd_Data,
  output logic [TS_W-1:0]        Rd_Ts,
  output logic                   Rd_Valid,
  output logic                   Empty,
  output logic                   Full,
  output logic [$clog2(DEPTH):0] Count,
  output logic                   Overflow,
  output logic                   Halt_Detected,
  output logic [1:0]             State
);
  localparam int EW = entry_w(DATA_W, TS_W);
  localparam int SW = $clog2(HALT_CYCLES + 1);
  state_t r_state, w_next;
  logic [TS_W-1:0] r_ts;
  logic [DATA_W-1:0] r_last;
  logic [SW-1:0] r_stable;
  logic r_first, r_ovf, r_halt;
  logic w_enter, w_active, w_same, w_cap, w_halt, w_lost, w_drop;
  logic [EW-1:0] w_rd_entry;
  assign w_enter  = r_state == ST_IDLE && Capture_En;
  assign w_active = r_state == ST_RUN && Capture_En;
  // the first RUN cycle has no previous sample, so it never counts as unchanged
  assign w_same   = !r_first && Test_Value == r_last;
  assign w_cap    = w_active && (MODE == MODE_EVERY || !w_same);
  assign w_halt   = w_active && w_same && r_stable == SW'(HALT_CYCLES - 1);
  assign w_drop   = w_lost && FULL_POLICY == FULL_STOP;
  assign Rd_Data       = w_rd_entry[EW-1 -: DATA_W];
  assign Rd_Ts         = w_rd_entry[TS_W-1:0];
  assign Overflow      = r_ovf;
  assign Halt_Detected = r_halt;
  assign State         = r_state;
  trace_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .i_clk      (CLK),
    .i_rst_n    (RST),
    .i_wr       (w_cap),
    .i_ovw      (FULL_POLICY == FULL_OVERWRITE),
    .i_rd       (Rd_En),
    .i_wr_data  ({Test_Value, r_ts}),
    .o_rd_data  (w_rd_entry),
    .o_rd_valid (Rd_Valid),
    .o_empty    (Empty),
    .o_full     (Full),
    .o_lost     (w_lost),
    .o_count    (Count)
  );
  always_comb begin
    w_next = ST_IDLE;
    case (r_state)
      ST_IDLE:    w_next = Capture_En ? ST_RUN : ST_IDLE;
      ST_RUN:     w_next = !Capture_En ? ST_IDLE : (w_halt || w_drop) ? ST_STOPPED : ST_RUN;
      ST_STOPPED: w_next = Capture_En ? ST_STOPPED : ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state  <= ST_IDLE;
      r_ts     <= '0;
      r_last   <= '0;
      r_stable <= '0;
      r_first  <= 1'b0;
      r_ovf    <= 1'b0;
      r_halt   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_ts     <= w_enter ? '0 : r_state == ST_RUN ? r_ts + 1'b1 : r_ts;
      r_last   <= w_active ? Test_Value : r_last;
      r_stable <= w_enter ? '0 : !w_active ? r_stable : w_same ? r_stable + 1'b1 : '0;
      r_first  <= w_enter ? 1'b1 : w_active ? 1'b0 : r_first;
      r_ovf    <= w_enter ? 1'b0 : r_ovf | w_lost;
      r_halt   <= w_enter ? 1'b0 : r_halt | w_halt;
    end
  end
endmodule

// File: tb/tb_mips_trace_buffer.sv
// tb_mips_trace_buffer: directed scenarios plus randomized runs against a queue-based reference model
module tb_mips_trace_buffer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn [3], ce [3], re [3];
  logic [15:0] tv [3];
  logic [15:0] rdd [3], rdt [3];
  logic rv [3], emp [3], ful [3], ovf [3], hlt [3];
  logic [2:0] cnt [3];
  logic [1:0] st [3];
  int n_chk, n_pass, n_fail, hold;
  int seq40 [5] = '{5, 5, 7, 7, 9};
  int exd40 [3] = '{5, 7, 9};
  int ext40 [3] = '{0, 2, 4};
  int md [3] = '{0, 1, 1};
  int fpl [3] = '{0, 0, 1};
  int m_st, m_stable;
  logic [15:0] m_ts, m_last, m_rdd, m_rdt;
  bit m_first, m_ovf, m_halt, m_rv;
  logic [31:0] mq [$];

  mips_trace_buffer #(.DEPTH(4), .MODE(0), .FULL_POLICY(0)) u0 (
    .CLK(clk), .RST(rstn[0]), .Test_Value(tv[0]), .Capture_En(ce[0]), .Rd_En(re[0]),
    .Rd_Data(rdd[0]), .Rd_Ts(rdt[0]), .Rd_Valid(rv[0]), .Empty(emp[0]), .Full(ful[0]),
    .Count(cnt[0]), .Overflow(ovf[0]), .Halt_Detected(hlt[0]), .State(st[0]));
  mips_trace_buffer #(.DEPTH(4), .MODE(1), .FULL_POLICY(0)) u1 (
    .CLK(clk), .RST(rstn[1]), .Test_Value(tv[1]), .Capture_En(ce[1]), .Rd_En(re[1]),
    .Rd_Data(rdd[1]), .Rd_Ts(rdt[1]), .Rd_Valid(rv[1]), .Empty(emp[1]), .Full(ful[1]),
    .Count(cnt[1]), .Overflow(ovf[1]), .Halt_Detected(hlt[1]), .State(st[1]));
  mips_trace_buffer #(.DEPTH(4), .MODE(1), .FULL_POLICY(1)) u2 (
    .CLK(clk), .RST(rstn[2]), .Test_Value(tv[2]), .Capture_En(ce[2]), .Rd_En(re[2]),
    .Rd_Data(rdd[2]), .Rd_Ts(rdt[2]), .Rd_Valid(rv[2]), .Empty(emp[2]), .Full(ful[2]),
    .Count(cnt[2]), .Overflow(ovf[2]), .Halt_Detected(hlt[2]), .State(st[2]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference: trace entries live in a queue; state follows the capture/halt/full rules directly
  task automatic model_step(input int k);
    bit rd_ok, act, same, cap, halt_now, drop;
    logic [31:0] e;
    if (!rstn[k]) begin
      m_st = 0; m_ts = 0; m_last = 0; m_first = 0; m_stable = 0;
      m_ovf = 0; m_halt = 0; m_rv = 0; m_rdd = 0; m_rdt = 0;
      mq.delete();
      return;
    end
    rd_ok = re[k] && mq.size() > 0;
    act = m_st == 1 && ce[k];
    same = !m_first && tv[k] == m_last;
    cap = act && (md[k] == 1 || !same);
    halt_now = act && same && m_stable + 1 == 8;
    drop = 0;
    m_rv = rd_ok;
    if (rd_ok) begin
      e = mq.pop_front();
      m_rdd = e[31:16];
      m_rdt = e[15:0];
    end
    if (cap) begin
      if (mq.size() < 4) mq.push_back({tv[k], m_ts});
      else if (fpl[k] == 1) begin
        void'(mq.pop_front());
        mq.push_back({tv[k], m_ts});
        m_ovf = 1;
      end else begin
        m_ovf = 1;
        drop = 1;
      end
    end
    if (act) begin
      m_stable = same ? m_stable + 1 : 0;
      m_last = tv[k];
      m_first = 0;
    end
    if (halt_now) m_halt = 1;
    if (m_st == 1) m_ts++;
    if (m_st == 0 && ce[k]) begin
      m_st = 1; m_ts = 0; m_first = 1; m_stable = 0; m_ovf = 0; m_halt = 0;
    end else if (m_st == 1) m_st = !ce[k] ? 0 : (halt_now || drop) ? 2 : 1;
    else if (m_st == 2 && !ce[k]) m_st = 0;
  endtask

  task automatic check_model(input int k);
    chk("rnd_state", 32'(st[k]), 32'(m_st));
    chk("rnd_count", 32'(cnt[k]), 32'(mq.size()));
    chk("rnd_empty", 32'(emp[k]), 32'(mq.size() == 0));
    chk("rnd_full", 32'(ful[k]), 32'(mq.size() == 4));
    chk("rnd_ovf", 32'(ovf[k]), 32'(m_ovf));
    chk("rnd_halt", 32'(hlt[k]), 32'(m_halt));
    chk("rnd_rv", 32'(rv[k]), 32'(m_rv));
    chk("rnd_rdata", 32'(rdd[k]), 32'(m_rdd));
    chk("rnd_rts", 32'(rdt[k]), 32'(m_rdt));
  endtask

  initial begin
    n_chk = 0; n_pass = 0; n_fail = 0;
    for (int k = 0; k < 3; k++) begin
      rstn[k] = 0; ce[k] = 0; re[k] = 0; tv[k] = 0;
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("rst_state", 32'(st[k]), 0);
      chk("rst_count", 32'(cnt[k]), 0);
      chk("rst_empty", 32'(emp[k]), 1);
      chk("rst_full", 32'(ful[k]), 0);
      chk("rst_ovf", 32'(ovf[k]), 0);
      chk("rst_halt", 32'(hlt[k]), 0);
      chk("rst_rv", 32'(rv[k]), 0);
      chk("rst_rdata", 32'(rdd[k]), 0);
      chk("rst_rts", 32'(rdt[k]), 0);
      rstn[k] = 1;
    end
    // change-mode capture
    ce[0] = 1; tv[0] = 5; tick();
    chk("m0_enter", 32'(st[0]), 1);
    for (int i = 0; i < 5; i++) begin
      tv[0] = 16'(seq40[i]); tick();
    end
    ce[0] = 0; tick();
    chk("m0_count", 32'(cnt[0]), 3);
    chk("m0_idle", 32'(st[0]), 0);
    re[0] = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("m0_rv", 32'(rv[0]), 1);
      chk("m0_rdata", 32'(rdd[0]), 32'(exd40[i]));
      chk("m0_rts", 32'(rdt[0]), 32'(ext40[i]));
    end
    chk("m0_empty", 32'(emp[0]), 1);
    tick();
    chk("empty_rd_rv", 32'(rv[0]), 0);
    chk("empty_rd_hold_d", 32'(rdd[0]), 9);
    chk("empty_rd_hold_t", 32'(rdt[0]), 4);
    re[0] = 0;
    // full with stop policy
    ce[1] = 1; tick();
    for (int i = 0; i < 6; i++) begin
      tv[1] = 16'(10 + i); tick();
      if (i == 3) begin
        chk("fs_count4", 32'(cnt[1]), 4);
        chk("fs_full", 32'(ful[1]), 1);
        chk("fs_ovf0", 32'(ovf[1]), 0);
        chk("fs_run", 32'(st[1]), 1);
      end
      if (i == 4) begin
        chk("fs_ovf1", 32'(ovf[1]), 1);
        chk("fs_stopped", 32'(st[1]), 2);
      end
      if (i == 5) begin
        chk("fs_count_end", 32'(cnt[1]), 4);
        chk("fs_stay_stop", 32'(st[1]), 2);
      end
    end
    ce[1] = 0; re[1] = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("fs_rts", 32'(rdt[1]), 32'(i));
      chk("fs_rdata", 32'(rdd[1]), 32'(10 + i));
    end
    chk("fs_idle", 32'(st[1]), 0);
    re[1] = 0; tick();
    chk("fs_empty", 32'(emp[1]), 1);
    // full with overwrite policy
    ce[2] = 1; tick();
    for (int i = 0; i < 6; i++) begin
      tv[2] = 16'(20 + i); tick();
      if (i == 3) chk("ow_ovf0", 32'(ovf[2]), 0);
      if (i == 4) chk("ow_ovf1", 32'(ovf[2]), 1);
      if (i == 5) begin
        chk("ow_count", 32'(cnt[2]), 4);
        chk("ow_run", 32'(st[2]), 1);
        chk("ow_full", 32'(ful[2]), 1);
      end
    end
    ce[2] = 0; re[2] = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ow_rts", 32'(rdt[2]), 32'(i + 2));
      chk("ow_rdata", 32'(rdd[2]), 32'(22 + i));
    end
    re[2] = 0; tick();
    chk("ow_empty", 32'(emp[2]), 1);
    // halt detection
    tv[0] = 3; ce[0] = 1; tick();
    for (int i = 0; i < 8; i++) tick();
    chk("halt_not_yet", 32'(hlt[0]), 0);
    chk("halt_still_run", 32'(st[0]), 1);
    tick();
    chk("halt_set", 32'(hlt[0]), 1);
    chk("halt_stopped", 32'(st[0]), 2);
    chk("halt_count", 32'(cnt[0]), 1);
    ce[0] = 0; tick();
    chk("halt_idle", 32'(st[0]), 0);
    chk("halt_sticky", 32'(hlt[0]), 1);
    ce[0] = 1; tick();
    chk("halt_rerun", 32'(st[0]), 1);
    chk("halt_cleared", 32'(hlt[0]), 0);
    ce[0] = 0; tick();
    // read and write together while full
    ce[1] = 1; tick();
    for (int i = 0; i < 4; i++) begin
      tv[1] = 16'(40 + i); tick();
    end
    chk("rw_full_pre", 32'(cnt[1]), 4);
    tv[1] = 50; re[1] = 1; tick();
    chk("rw_full_count", 32'(cnt[1]), 4);
    chk("rw_full_ovf", 32'(ovf[1]), 0);
    chk("rw_full_run", 32'(st[1]), 1);
    chk("rw_full_rv", 32'(rv[1]), 1);
    chk("rw_full_rdata", 32'(rdd[1]), 40);
    chk("rw_full_rts", 32'(rdt[1]), 0);
    re[1] = 0; ce[1] = 0; tick();
    // read and write together while empty, then reset mid-run
    ce[2] = 1; tick();
    tv[2] = 60; re[2] = 1; tick();
    chk("rw_empty_count", 32'(cnt[2]), 1);
    chk("rw_empty_rv", 32'(rv[2]), 0);
    re[2] = 0;
    tv[2] = 61; tick();
    tv[2] = 62; tick();
    chk("mid_count3", 32'(cnt[2]), 3);
    rstn[2] = 0; re[2] = 1; tick();
    chk("mid_rst_count", 32'(cnt[2]), 0);
    chk("mid_rst_empty", 32'(emp[2]), 1);
    chk("mid_rst_state", 32'(st[2]), 0);
    chk("mid_rst_rv", 32'(rv[2]), 0);
    rstn[2] = 1; re[2] = 0; ce[2] = 0; tick();
    chk("mid_rst_rv_after", 32'(rv[2]), 0);
    // randomized traffic per configuration
    for (int k = 0; k < 3; k++) begin
      rstn[k] = 0; ce[k] = 0; re[k] = 0;
      model_step(k); tick(); check_model(k);
      rstn[k] = 1;
      hold = 0;
      for (int c = 0; c < 400; c++) begin
        if (hold > 0) hold--;
        else if ($urandom_range(0, 19) == 0) hold = 12;
        else tv[k] = 16'($urandom_range(0, 3));
        ce[k] = $urandom_range(0, 99) < 92;
        re[k] = $urandom_range(0, 99) < 35;
        rstn[k] = $urandom_range(0, 99) >= 1;
        model_step(k); tick(); check_model(k);
      end
      ce[k] = 0; re[k] = 0; rstn[k] = 1;
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
